// File: rtl/crc_block_engine.sv
// Sequencing CRC engine: owns the SRAM port and runs a programmable CRC over a
// contiguous, address-wrapping block of stored words, one word per cycle.
module crc_block_engine #(
    parameter int ADDR_WIDTH = 11,
    parameter int WORD_WIDTH = 32,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [WORD_WIDTH-1:0] host_wdata,
    output logic                  host_err,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [CRC_WIDTH-1:0]  poly,
    input  logic [CRC_WIDTH-1:0]  init,
    input  logic [CRC_WIDTH-1:0]  xor_out,
    input  logic                  reflect_in,
    input  logic                  reflect_out,
    output logic                  busy,
    output logic                  done,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_din,
    input  logic [WORD_WIDTH-1:0] mem_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [CRC_WIDTH-1:0]  poly_r;
    logic [CRC_WIDTH-1:0]  xor_r;
    logic                  refl_in_r;
    logic                  refl_out_r;
    logic                  idle;
    logic                  accept;
    logic [CRC_WIDTH-1:0]  crc_next;

    function automatic logic [WORD_WIDTH-1:0] rev_word(input logic [WORD_WIDTH-1:0] w);
        logic [WORD_WIDTH-1:0] r;
        for (int i = 0; i < WORD_WIDTH; i++) r[i] = w[WORD_WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] rev_crc(input logic [CRC_WIDTH-1:0] c);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
        return r;
    endfunction

    // Whole word folded in MSB-first within a single cycle.
    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0]  c_in,
        input logic [WORD_WIDTH-1:0] word,
        input logic [CRC_WIDTH-1:0]  p,
        input logic                  rin
    );
        logic [WORD_WIDTH-1:0] d;
        logic [CRC_WIDTH-1:0]  c;
        logic                  fb;
        d = rin ? rev_word(word) : word;
        c = c_in;
        for (int b = WORD_WIDTH - 1; b >= 0; b--) begin
            fb = c[CRC_WIDTH-1] ^ d[b];
            c  = (c << 1) ^ (fb ? p : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] finalize(
        input logic [CRC_WIDTH-1:0] c,
        input logic                 rout,
        input logic [CRC_WIDTH-1:0] x
    );
        return (rout ? rev_crc(c) : c) ^ x;
    endfunction

    assign idle     = (state == IDLE);
    assign accept   = idle && start && !host_we;
    assign crc_next = crc_step(crc_reg, mem_dout, poly_r, refl_in_r);

    // The first read goes out in the accept cycle itself, so the SRAM port is
    // driven combinationally from the live request inputs while idle.
    always_comb begin
        mem_csb  = 1'b1;
        mem_web  = 1'b1;
        mem_addr = read_addr;
        mem_din  = '0;
        if (!rst) begin
            if (idle && host_we) begin
                mem_csb  = 1'b0;
                mem_web  = 1'b0;
                mem_addr = host_addr;
                mem_din  = host_wdata;
            end else if (accept && length != '0) begin
                mem_csb  = 1'b0;
                mem_addr = base_addr;
            end else if (state == RUN) begin
                mem_csb  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            read_addr  <= '0;
            remaining  <= '0;
            crc_reg    <= '0;
            poly_r     <= '0;
            xor_r      <= '0;
            refl_in_r  <= 1'b0;
            refl_out_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            host_err   <= 1'b0;
            crc_out    <= '0;
        end else begin
            done     <= 1'b0;
            host_err <= host_we && !idle;
            case (state)
                IDLE: begin
                    if (accept) begin
                        poly_r     <= poly;
                        xor_r      <= xor_out;
                        refl_in_r  <= reflect_in;
                        refl_out_r <= reflect_out;
                        crc_reg    <= init;
                        read_addr  <= base_addr + ADDR_ONE;
                        remaining  <= length - CNT_ONE;
                        if (length == '0) begin
                            done    <= 1'b1;
                            crc_out <= finalize(init, reflect_out, xor_out);
                            state   <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= (length == CNT_ONE) ? FLUSH : RUN;
                        end
                    end
                end
                RUN: begin
                    crc_reg   <= crc_next;
                    read_addr <= read_addr + ADDR_ONE;
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) state <= FLUSH;
                end
                FLUSH: begin
                    crc_reg <= crc_next;
                    crc_out <= finalize(crc_next, refl_out_r, xor_r);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_block_engine.sv
// Directed bench for crc_block_engine with a 1-cycle-latency SRAM model.
module tb_crc_block_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_we;
    logic [10:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_err;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] length;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xor_out;
    logic        reflect_in;
    logic        reflect_out;
    logic        busy;
    logic        done;
    logic [31:0] crc_out;
    logic        mem_csb;
    logic        mem_web;
    logic [10:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] sram [0:2047];

    int vectors = 0;
    int miscompares = 0;

    crc_block_engine dut (
        .clk(clk), .rst(rst),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_err(host_err),
        .start(start), .base_addr(base_addr), .length(length), .poly(poly), .init(init),
        .xor_out(xor_out), .reflect_in(reflect_in), .reflect_out(reflect_out),
        .busy(busy), .done(done), .crc_out(crc_out),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_csb) begin
            if (!mem_web) sram[mem_addr] <= mem_din;
            else          mem_dout <= sram[mem_addr];
        end
    end

    task automatic host_write(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // Starts a job in the next cycle (cycle 0) and follows it until done.
    task automatic run_job(input string name, input logic [10:0] b, input logic [11:0] len,
                           input logic [31:0] p, input logic [31:0] ini, input logic [31:0] xo,
                           input logic rin, input logic rout, input logic [31:0] exp_crc);
        int done_cycle;
        int exp_cycle;
        int busy_bad;
        int held_bad;
        logic [31:0] prev_crc;
        done_cycle = -1;
        busy_bad   = 0;
        held_bad   = 0;
        exp_cycle  = (len == 0) ? 1 : int'(len) + 1;
        @(negedge clk);
        prev_crc    = crc_out;
        base_addr   = b;
        length      = len;
        poly        = p;
        init        = ini;
        xor_out     = xo;
        reflect_in  = rin;
        reflect_out = rout;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= int'(len) + 10; cyc++) begin
            if (busy !== ((len != 0) && (cyc <= int'(len)))) busy_bad++;
            if (done === 1'b1) begin
                done_cycle = cyc;
                break;
            end
            if (crc_out !== prev_crc) held_bad++;
            @(negedge clk);
        end
        vectors++;
        if (done_cycle != exp_cycle) begin
            miscompares++;
            $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_cycle, exp_cycle);
        end
        vectors++;
        if (crc_out !== exp_crc) begin
            miscompares++;
            $display("[TB] FAIL %s crc_out: got %h expected %h", name, crc_out, exp_crc);
        end
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL %s busy_window: got %0d bad cycles expected 0", name, busy_bad);
        end
        vectors++;
        if (held_bad != 0) begin
            miscompares++;
            $display("[TB] FAIL %s crc_hold: got %0d early changes expected 0", name, held_bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, host_err, mem_csb, mem_web} !== 5'b00011) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00011", {busy, done, host_err, mem_csb, mem_web});
        end
        vectors++;
        if (crc_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_crc: got %h expected 00000000", crc_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        host_write(11'd5, 32'h0000_0001);
        run_job("single", 11'd5, 12'd1, 32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h04C11DB7);
    endtask

    task automatic test_wrap();
        host_write(11'h7FF, 32'h0000_0000);
        host_write(11'h000, 32'h0000_0001);
        run_job("wrap", 11'h7FF, 12'd2, 32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h04C11DB7);
    endtask

    task automatic test_init_xor();
        host_write(11'd10, 32'hFFFF_FFFF);
        run_job("init_ones", 11'd10, 12'd1, 32'h04C11DB7, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0000_0000);
        run_job("xor_ones", 11'd10, 12'd1, 32'h04C11DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
    endtask

    task automatic test_reflect();
        host_write(11'd11, 32'h8000_0000);
        run_job("reflect_in", 11'd11, 12'd1, 32'h04C11DB7, 32'h0, 32'h0, 1'b1, 1'b0, 32'h04C11DB7);
        run_job("reflect_out", 11'd5, 12'd1, 32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b1, 32'hEDB88320);
    endtask

    task automatic test_zero_length();
        run_job("len0", 11'd3, 12'd0, 32'h04C11DB7, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h12345678);
    endtask

    task automatic test_host_err();
        int done_cycle;
        done_cycle = -1;
        host_write(11'd20, 32'hAAAA_5555);
        vectors++;
        if (host_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_write_err: got %b expected 0", host_err);
        end
        @(negedge clk);
        base_addr = 11'd16;
        length    = 12'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = 11'd20;
        host_wdata = 32'h0;
        @(negedge clk);
        host_we = 1'b0;
        vectors++;
        if (host_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL host_err_pulse: got %b expected 1", host_err);
        end
        @(negedge clk);
        vectors++;
        if (host_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL host_err_clear: got %b expected 0", host_err);
        end
        for (int cyc = 4; cyc < 20; cyc++) begin
            if (done === 1'b1) begin
                done_cycle = cyc;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (done_cycle != 5) begin
            miscompares++;
            $display("[TB] FAIL host_err_done_cycle: got %0d expected 5", done_cycle);
        end
        vectors++;
        if (sram[20] !== 32'hAAAA_5555) begin
            miscompares++;
            $display("[TB] FAIL host_err_word: got %h expected aaaa5555", sram[20]);
        end
    endtask

    task automatic test_reset_mid_job();
        int saw_done;
        saw_done = 0;
        @(negedge clk);
        base_addr = 11'd0;
        length    = 12'd8;
        init      = 32'h0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL midjob_reset_ctrl: got %b expected 00", {busy, done});
        end
        vectors++;
        if (crc_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midjob_reset_crc: got %h expected 00000000", crc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done++;
            @(negedge clk);
        end
        vectors++;
        if (saw_done != 0) begin
            miscompares++;
            $display("[TB] FAIL midjob_no_done: got %0d active cycles expected 0", saw_done);
        end
        run_job("after_reset", 11'd5, 12'd1, 32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h04C11DB7);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_first", 11'd10, 12'd1, 32'h04C11DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run_job("b2b_second", 11'h7FF, 12'd2, 32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h04C11DB7);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) sram[i] = 32'h0;
        mem_dout    = 32'h0;
        host_we     = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        poly        = 32'h04C11DB7;
        init        = '0;
        xor_out     = '0;
        reflect_in  = 1'b0;
        reflect_out = 1'b0;
        test_reset();
        test_single_word();
        test_wrap();
        test_init_xor();
        test_reflect();
        test_zero_length();
        test_host_err();
        test_reset_mid_job();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc_block_engine.md
# crc_block_engine

Sequencing CRC engine that owns the word SRAM port and computes a programmable CRC over a contiguous block of stored words without host involvement. It is the parametrised successor to the single-word combinational CRC path. Generalisations:
- width parameters
- runtime polynomial, init, final-XOR and reflection modes
- start/busy/done handshake over a wrapping address range

It sits between the host write interface and the SRAM macro. The macro has a 1-cycle read latency.

## Interface
- ADDR_WIDTH, 11, SRAM word-address width
- WORD_WIDTH, 32, data word width; bits consumed per cycle
- CRC_WIDTH, 32, CRC register and polynomial width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- host_we  in  1  host write request
- host_addr  in  ADDR_WIDTH  host write address
- host_wdata  in  WORD_WIDTH  host write data
- host_err  out  1  one-cycle pulse: host write dropped because engine busy
- start  in  1  start request, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH
- poly  in  CRC_WIDTH  generator polynomial, implicit top bit
- init  in  CRC_WIDTH  CRC preset
- xor_out  in  CRC_WIDTH  final XOR mask
- reflect_in  in  1  bit-reverse each data word before use
- reflect_out  in  1  bit-reverse CRC before final XOR
- busy  out  1  job in progress
- done  out  1  one-cycle pulse; crc_out updated this cycle
- crc_out  out  CRC_WIDTH  result of the last completed job, held until the next done
- mem_csb  out  1  SRAM chip select, active-low
- mem_web  out  1  SRAM write enable, active-low (1 = read)
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_din  out  WORD_WIDTH  SRAM write data
- mem_dout  in  WORD_WIDTH  SRAM read data, valid 1 cycle after read issue

## Operation
- States:
  - IDLE
  - RUN: issue reads, accumulate
  - FLUSH: accumulate last word
  - DONE: finalise, pulse done
- Registered outputs reset to 0: busy, done, host_err, crc_out.
- mem_csb and mem_web reset to 1 (macro idle).
- IDLE with host_we=1: drive mem_csb=0, mem_web=0, mem_addr=host_addr, mem_din=host_wdata. Host writes take priority over start in the same cycle; the start is ignored.
- IDLE, start=1, host_we=0:
  - Latch base_addr, length, poly, xor_out, reflect_in and reflect_out. Set crc_reg=init.
  - length=0: go to DONE.
  - Otherwise go to RUN, busy=1.
- RUN:
  - Issue one read per cycle at base_addr+k, for k = 0..length-1, modulo 2^ADDR_WIDTH.
  - Accumulate the word returned from the previous cycle's read.
  - After the final issue, go to FLUSH.
- FLUSH: accumulate the last word, go to DONE.
- DONE:
  - crc_out = (reflect_out ? bitrev(crc_reg) : crc_reg) ^ xor_out.
  - done=1, busy=0, return to IDLE.
- Accumulation per word, MSB-first:
  - d = reflect_in ? bitrev(word) : word.
  - For b = WORD_WIDTH-1 down to 0: fb = crc[CRC_WIDTH-1] ^ d[b]; crc = (crc<<1) ^ (fb ? poly : 0).
  - The whole word is done combinationally in one cycle.
- host_we while not IDLE: write dropped, host_err=1 for that cycle, SRAM untouched.
- start while not IDLE: ignored.
- Configuration inputs are don't-care after acceptance.
- rst asserted mid-job: immediate return to IDLE, outputs to reset values, no done pulse.

## Timing
- Accept at cycle 0. Reads issue in cycles 0..N-1, accumulation in cycles 1..N.
- N ≥ 1: done pulses in cycle N+1 and busy is high in cycles 1..N.
- N = 0: done pulses in cycle 1 and busy never rises.
- crc_out changes only in the done cycle.
- A new start is accepted in the cycle after done at the earliest.
- Address wrap: base_addr=2^ADDR_WIDTH-1 with length=2 reads the last address, then 0.

## Test plan
- Write word 0x00000001 at 5, then job base=5, len=1, poly=0x04C11DB7, init=0, xor_out=0, no reflect -> done in cycle 2, crc_out=0x04C11DB7.
- Words 0x00000000 at 0x7FF and 0x00000001 at 0x000, job base=0x7FF, len=2, same config -> address wraps; done in cycle 3, crc_out=0x04C11DB7.
- Word 0xFFFFFFFF, init=0xFFFFFFFF, len=1 -> crc_out=0x00000000. Repeat with xor_out=0xFFFFFFFF -> 0xFFFFFFFF.
- Word 0x80000000, reflect_in=1, init=0 -> 0x04C11DB7. Word 0x00000001, reflect_out=1 -> 0xEDB88320.
- len=0, init=0x12345678, xor_out=0 -> done in cycle 1, crc_out=0x12345678, busy never high.
- Host write during RUN -> host_err pulses, target word unchanged. rst at cycle 2 of a len=8 job -> busy=0, no done, crc_out=0. A following len=1 job completes normally.
